// File: rtl/lfsr_checker.sv
// Receive-side checker for the 8-bit LFSR pattern (x^8+x^6+x^5+x^4+1): searches, verifies, locks, counts errors.
// Define LFSR_CHK_BITCNT_EN to count mismatching bits instead of mismatching words.
module lfsr_checker #(
   parameter int LOCK_COUNT = 4,
   parameter int LOSS_COUNT = 3,
   parameter int ERR_W      = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   input  logic [7:0]       in_data,
   input  logic             clr_err,
   output logic             locked,
   output logic             err_pulse,
   output logic [ERR_W-1:0] err_count,
   output logic [7:0]       exp_data
);

   typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} state_t;

   localparam int              SUM_W   = ERR_W + 4;
   localparam logic [SUM_W-1:0] ERR_MAX = {4'b0, {ERR_W{1'b1}}};

   state_t           state, state_nxt;
   logic [3:0]       match_cnt, match_nxt;
   logic [3:0]       miss_cnt, miss_nxt;
   logic [7:0]       exp_nxt;
   logic             locked_nxt, pulse_nxt, count_err;
   logic [3:0]       err_inc;
   logic [SUM_W-1:0] err_sum;
   logic [ERR_W-1:0] cnt_nxt;

   function automatic logic [7:0] lfsr_next(input logic [7:0] x);
      return {x[6:0], x[7] ^ x[5] ^ x[4] ^ x[3]};
   endfunction

`ifdef LFSR_CHK_BITCNT_EN
   function automatic logic [3:0] popcount(input logic [7:0] x);
      logic [3:0] n;
      n = 4'd0;
      for (int i = 0; i < 8; i++) n = n + {3'b000, x[i]};
      return n;
   endfunction
`endif

   always_comb begin
      // NOTE: every output of this block gets a default first so no path can infer a latch.
      state_nxt  = state;
      match_nxt  = match_cnt;
      miss_nxt   = miss_cnt;
      exp_nxt    = exp_data;
      locked_nxt = locked;
      pulse_nxt  = 1'b0;
      count_err  = 1'b0;
      if (in_valid) begin
         case (state)
            SEARCH: begin
               if (in_data != 8'h00) begin
                  exp_nxt   = lfsr_next(in_data);
                  match_nxt = 4'd0;
                  state_nxt = VERIFY;
               end
            end
            VERIFY: begin
               if (in_data == exp_data) begin
                  match_nxt = match_cnt + 4'd1;
                  exp_nxt   = lfsr_next(in_data);
                  if (match_nxt == 4'(LOCK_COUNT)) begin
                     state_nxt  = LOCKED;
                     locked_nxt = 1'b1;
                     miss_nxt   = 4'd0;
                  end
               end else if (in_data == 8'h00) begin
                  state_nxt = SEARCH;
                  match_nxt = 4'd0;
               end else begin
                  exp_nxt   = lfsr_next(in_data);
                  match_nxt = 4'd0;
               end
            end
            LOCKED: begin
               // Flywheel only: re-seeding from a bad word would turn one error into many.
               exp_nxt = lfsr_next(exp_data);
               if (in_data == exp_data) begin
                  miss_nxt = 4'd0;
               end else begin
                  pulse_nxt = 1'b1;
                  count_err = 1'b1;
                  miss_nxt  = miss_cnt + 4'd1;
                  if (miss_nxt == 4'(LOSS_COUNT)) begin
                     state_nxt  = SEARCH;
                     locked_nxt = 1'b0;
                     miss_nxt   = 4'd0;
                     match_nxt  = 4'd0;
                  end
               end
            end
            default: begin
               state_nxt  = SEARCH;
               locked_nxt = 1'b0;
            end
         endcase
      end

`ifdef LFSR_CHK_BITCNT_EN
      err_inc = popcount(in_data ^ exp_data);
`else
      err_inc = 4'd1;
`endif
      // A clear coinciding with a counted error restarts the count from that error.
      err_sum = (clr_err ? '0 : {4'b0, err_count})
              + (count_err ? {{ERR_W{1'b0}}, err_inc} : '0);
      cnt_nxt = (err_sum > ERR_MAX) ? '1 : err_sum[ERR_W-1:0];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= SEARCH;
         match_cnt <= 4'd0;
         miss_cnt  <= 4'd0;
         locked    <= 1'b0;
         err_pulse <= 1'b0;
         err_count <= '0;
         exp_data  <= 8'h00;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         state     <= state_nxt;
         match_cnt <= match_nxt;
         miss_cnt  <= miss_nxt;
         locked    <= locked_nxt;
         err_pulse <= pulse_nxt;
         err_count <= cnt_nxt;
         exp_data  <= exp_nxt;
      end
   end

endmodule
